// File: rtl/core_pkg.sv
// Core-wide constants and types shared by the architectural register file.
//   NumAregs            : number of architectural registers
//   arf_restore_state_t : restore stream FSM states
package core_pkg;

  localparam int unsigned NumAregs = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } arf_restore_state_t;

endpackage

// File: rtl/arf_restore_seq.sv
// Restore stream sequencer: walks a pointer over every architectural register index
// after a restore request, presenting one beat per index on a valid/ready channel.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   restore_req_i     : start a stream (honoured only when idle)
//   restore_ready_i   : consumer accepts the current beat
//   ptr_o             : index of the current beat
//   restore_valid_o   : a beat is presented
//   restore_busy_o    : sequencer is not idle
//   restore_done_o    : one-cycle pulse after the last beat is accepted
module arf_restore_seq
  import core_pkg::*;
#(
  parameter int unsigned NumRegs = NumAregs,
  parameter int unsigned IdxW    = $clog2(NumRegs)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            restore_req_i,
  input  logic            restore_ready_i,
  output logic [IdxW-1:0] ptr_o,
  output logic            restore_valid_o,
  output logic            restore_busy_o,
  output logic            restore_done_o
);

  arf_restore_state_t state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    restore_valid_o = 1'b0;
    restore_done_o  = 1'b0;
    restore_busy_o  = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (restore_req_i) begin
          state_d = StStream;
          ptr_d   = '0;
        end
      end
      StStream: begin
        restore_valid_o = 1'b1;
        // ptr only moves on a handshake, so it is held stable through stalls
        if (restore_ready_i) begin
          if (ptr_q == IdxW'(NumRegs - 1)) begin
            state_d = StDone;
          end else begin
            ptr_d = ptr_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        restore_done_o = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/arch_reg_file.sv
// Architectural register file at the commit end of the ROB. Accepts one in-order
// commit per cycle, serves two registered read ports with same-cycle commit bypass,
// counts commits, and streams its contents out over a restore channel after a flush.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rob_valid/dst_val/dst_index   : commit from the ROB (index 0 writes are dropped)
//   rd_idx_a/b, rd_val_a/b        : read addresses and registered read data
//   restore_req/ready             : restore start and consumer handshake
//   restore_valid/idx/val         : current restore beat
//   restore_busy, restore_done    : stream in progress, end-of-stream pulse
//   commit_count                  : free-running count of commits (wraps)
module arch_reg_file
  import core_pkg::*;
#(
  parameter int unsigned NUM_AREGS = NumAregs,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned IDX_W    = $clog2(NUM_AREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rob_valid,
  input  logic [DATA_W-1:0] rob_dst_val,
  input  logic [IDX_W-1:0]  rob_dst_index,
  input  logic [IDX_W-1:0]  rd_idx_a,
  input  logic [IDX_W-1:0]  rd_idx_b,
  output logic [DATA_W-1:0] rd_val_a,
  output logic [DATA_W-1:0] rd_val_b,
  input  logic              restore_req,
  output logic              restore_valid,
  output logic [IDX_W-1:0]  restore_idx,
  output logic [DATA_W-1:0] restore_val,
  input  logic              restore_ready,
  output logic              restore_busy,
  output logic              restore_done,
  output logic [31:0]       commit_count
);

  logic [DATA_W-1:0] regs_q [NUM_AREGS];
  logic [DATA_W-1:0] regs_d [NUM_AREGS];
  logic [DATA_W-1:0] rd_val_a_q, rd_val_a_d;
  logic [DATA_W-1:0] rd_val_b_q, rd_val_b_d;
  logic [31:0]       commit_count_q, commit_count_d;
  logic [IDX_W-1:0]  ptr;
  logic              wr_en;

  assign wr_en = rob_valid && (rob_dst_index != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[rob_dst_index] = rob_dst_val;
    end
  end

  // Reads see the commit of the same cycle; index 0 is forced to zero.
  always_comb begin
    rd_val_a_d = regs_q[rd_idx_a];
    if (rd_idx_a == '0) begin
      rd_val_a_d = '0;
    end else if (wr_en && (rob_dst_index == rd_idx_a)) begin
      rd_val_a_d = rob_dst_val;
    end
    rd_val_b_d = regs_q[rd_idx_b];
    if (rd_idx_b == '0) begin
      rd_val_b_d = '0;
    end else if (wr_en && (rob_dst_index == rd_idx_b)) begin
      rd_val_b_d = rob_dst_val;
    end
  end

  // Counts all commits, including dropped writes to index 0.
  always_comb begin
    commit_count_d = commit_count_q;
    if (rob_valid) begin
      commit_count_d = commit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q         <= '{default: '0};
      rd_val_a_q     <= '0;
      rd_val_b_q     <= '0;
      commit_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      rd_val_a_q     <= rd_val_a_d;
      rd_val_b_q     <= rd_val_b_d;
      commit_count_q <= commit_count_d;
    end
  end

  arf_restore_seq #(
    .NumRegs (NUM_AREGS),
    .IdxW    (IDX_W)
  ) u_restore_seq (
    .clk_i           (clk),
    .rst_i           (rst),
    .restore_req_i   (restore_req),
    .restore_ready_i (restore_ready),
    .ptr_o           (ptr),
    .restore_valid_o (restore_valid),
    .restore_busy_o  (restore_busy),
    .restore_done_o  (restore_done)
  );

  assign restore_idx  = ptr;
  // Straight from the array, so a commit to ptr shows up on the next cycle.
  assign restore_val  = regs_q[ptr];
  assign rd_val_a     = rd_val_a_q;
  assign rd_val_b     = rd_val_b_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_arch_reg_file.sv
// Bench for arch_reg_file: behavioural model plus directed literal checks and a
// randomized commit/read/restore phase.
module tb_arch_reg_file;

  localparam int NA = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_valid;
  logic [31:0] rob_dst_val;
  logic [4:0]  rob_dst_index;
  logic [4:0]  rd_idx_a, rd_idx_b;
  logic [31:0] rd_val_a, rd_val_b;
  logic        restore_req, restore_valid, restore_ready, restore_busy, restore_done;
  logic [4:0]  restore_idx;
  logic [31:0] restore_val;
  logic [31:0] commit_count;

  arch_reg_file dut (
    .clk           (clk),
    .rst           (rst),
    .rob_valid     (rob_valid),
    .rob_dst_val   (rob_dst_val),
    .rob_dst_index (rob_dst_index),
    .rd_idx_a      (rd_idx_a),
    .rd_idx_b      (rd_idx_b),
    .rd_val_a      (rd_val_a),
    .rd_val_b      (rd_val_b),
    .restore_req   (restore_req),
    .restore_valid (restore_valid),
    .restore_idx   (restore_idx),
    .restore_val   (restore_val),
    .restore_ready (restore_ready),
    .restore_busy  (restore_busy),
    .restore_done  (restore_done),
    .commit_count  (commit_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic checks_on = 1'b0;
  logic wrap_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state after each edge, and the restore stream
  // described as a phase plus the number of beats already accepted.
  logic [31:0] mregs [NA];
  logic [31:0] mcount;
  logic [31:0] exp_a, exp_b;
  int          mphase;  // 0 idle, 1 streaming, 2 done pulse
  int          mbeat;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NA; i++) mregs[i] = '0;
      mcount = '0;
      exp_a  = '0;
      exp_b  = '0;
      mphase = 0;
      mbeat  = 0;
    end else begin
      if (mphase == 0) begin
        if (restore_req) begin
          mphase = 1;
          mbeat  = 0;
        end
      end else if (mphase == 1) begin
        if (restore_ready) begin
          mbeat++;
          if (mbeat == NA) mphase = 2;
        end
      end else begin
        mphase = 0;
      end
      if (rob_valid) begin
        mcount = mcount + 32'd1;
        if (rob_dst_index != 0) mregs[rob_dst_index] = rob_dst_val;
      end
      if (wrap_req) mcount = 32'hFFFF_FFFF;
      // A read returns the architectural state including this cycle's commit.
      exp_a = mregs[rd_idx_a];
      exp_b = mregs[rd_idx_b];
    end
  end

  always @(negedge clk) begin
    if (checks_on) begin
      chk("rd_val_a", rd_val_a, exp_a);
      chk("rd_val_b", rd_val_b, exp_b);
      chk("commit_count", commit_count, mcount);
      chk("restore_valid", 32'(restore_valid), 32'(mphase == 1));
      chk("restore_busy", 32'(restore_busy), 32'(mphase != 0));
      chk("restore_done", 32'(restore_done), 32'(mphase == 2));
      if (mphase == 1) begin
        chk("restore_idx", 32'(restore_idx), 32'(mbeat));
        chk("restore_val", restore_val, mregs[mbeat]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int c;
    logic got_done;

    rst = 1'b1;
    rob_valid = 0; rob_dst_val = 0; rob_dst_index = 0;
    rd_idx_a = 0; rd_idx_b = 0; restore_req = 0; restore_ready = 0;
    cyc();
    cyc();
    rst = 1'b0;
    checks_on = 1'b1;
    chk("reset rd_val_a", rd_val_a, 32'h0);
    chk("reset commit_count", commit_count, 32'h0);
    chk("reset restore_busy", 32'(restore_busy), 32'h0);

    // Commit with same-cycle read: bypass, then plain read.
    rob_valid = 1; rob_dst_index = 5; rob_dst_val = 32'hDEAD_BEEF; rd_idx_a = 5;
    cyc();
    rob_valid = 0;
    chk("bypass x5", rd_val_a, 32'hDEAD_BEEF);
    cyc();
    chk("read x5", rd_val_a, 32'hDEAD_BEEF);

    // Write to x0 is dropped but counted.
    rob_valid = 1; rob_dst_index = 0; rob_dst_val = 32'h1234; rd_idx_b = 0;
    cyc();
    rob_valid = 0;
    chk("x0 read", rd_val_b, 32'h0);
    chk("x0 counted", commit_count, 32'd2);

    // regs[i] = i*0x11, then full-rate restore.
    for (int i = 1; i < NA; i++) begin
      rob_valid = 1; rob_dst_index = 5'(i); rob_dst_val = 32'(i * 32'h11);
      cyc();
    end
    rob_valid = 0;
    restore_ready = 1; restore_req = 1;
    cyc();
    restore_req = 0;
    for (int i = 0; i < NA; i++) begin
      chk("full beat valid", 32'(restore_valid), 32'h1);
      chk("full beat idx", 32'(restore_idx), 32'(i));
      chk("full beat val", restore_val, 32'(i * 32'h11));
      cyc();
    end
    chk("done at N+33", 32'(restore_done), 32'h1);
    restore_req = 1;  // ignored in the done cycle
    cyc();
    restore_req = 0;
    chk("done one cycle", 32'(restore_done), 32'h0);
    chk("idle after done", 32'(restore_busy), 32'h0);

    // Stalled restore, ready pattern 1,0,0,1.
    restore_req = 1;
    cyc();
    restore_req = 0;
    accepted = 0; got_done = 0; c = 0;
    while (!got_done && c < 400) begin
      restore_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (restore_done) begin
        got_done = 1;
      end else begin
        if (restore_valid && restore_ready) begin
          chk("stall beat idx", 32'(restore_idx), 32'(accepted));
          accepted++;
        end
        cyc();
        c++;
      end
    end
    chk("stall got done", 32'(got_done), 32'h1);
    chk("stall beats", 32'(accepted), 32'd32);
    cyc();

    // Reset mid-stream at ptr 10.
    restore_ready = 1; restore_req = 1;
    cyc();
    restore_req = 0;
    c = 0;
    while (restore_idx != 5'd10 && c < 40) begin
      cyc();
      c++;
    end
    chk("reached ptr 10", 32'(restore_idx), 32'd10);
    rst = 1;
    cyc();
    rst = 0;
    chk("rst valid", 32'(restore_valid), 32'h0);
    chk("rst busy", 32'(restore_busy), 32'h0);
    chk("rst done", 32'(restore_done), 32'h0);
    chk("rst idx", 32'(restore_idx), 32'h0);
    chk("rst count", commit_count, 32'h0);
    chk("rst rd_val_a", rd_val_a, 32'h0);
    cyc();
    chk("no done after rst", 32'(restore_done), 32'h0);
    restore_req = 1;
    cyc();
    restore_req = 0;
    chk("restart idx", 32'(restore_idx), 32'h0);
    chk("restart valid", 32'(restore_valid), 32'h1);
    for (int i = 0; i < NA + 2; i++) cyc();

    // commit_count wrap.
    checks_on = 0;
    force dut.commit_count_q = 32'hFFFF_FFFF;
    wrap_req = 1;
    cyc();
    wrap_req = 0;
    release dut.commit_count_q;
    checks_on = 1;
    cyc();
    chk("count preload", commit_count, 32'hFFFF_FFFF);
    rob_valid = 1; rob_dst_index = 3; rob_dst_val = 32'h55;
    cyc();
    rob_valid = 0;
    chk("count wrap", commit_count, 32'h0);

    // Random traffic with occasional restores and random backpressure.
    for (int i = 0; i < 600; i++) begin
      rob_valid     = 1'($urandom_range(0, 1));
      rob_dst_index = 5'($urandom_range(0, NA - 1));
      rob_dst_val   = $urandom;
      rd_idx_a      = ($urandom_range(0, 3) == 0) ? rob_dst_index : 5'($urandom_range(0, NA - 1));
      rd_idx_b      = 5'($urandom_range(0, NA - 1));
      restore_req   = ($urandom_range(0, 15) == 0);
      restore_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rob_valid = 0; restore_req = 0; restore_ready = 1;
    for (int i = 0; i < NA + 4; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
